// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - Two-port round-robin arbiter and cycle sequencer for a 256K x 16 async SRAM
// Every SRAM pin is a flop whose next value is decoded from the next FSM state.
module sram_arbiter #(
  parameter int AW          = 18,
  parameter int DW          = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic [1:0]    be0,
  input  logic [1:0]    be1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          busy,
  output logic          CE,
  output logic          OE,
  output logic          WE,
  output logic          LB,
  output logic          UB,
  output logic [AW-1:0] A,
  inout  wire  [DW-1:0] D
);
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;
  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          port_q, port_d;
  logic          wr_q, wr_d;
  logic [1:0]    be_q, be_d;
  logic [AW-1:0] a_q, a_d;
  logic [DW-1:0] d_out_q, d_out_d;
  logic          d_oe_q, d_oe_d;
  logic          ce_q, ce_d, oe_q, oe_d, we_q, we_d, lb_q, lb_d, ub_q, ub_d;
  logic          ack0_q, ack0_d, ack1_q, ack1_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic          sel1, wr_in;
  logic [1:0]    be_in;
  logic [DW-1:0] lane_mask;

  always_comb begin
    // last_q=1 means port 1 went last, so port 0 wins a tie
    sel1      = req1 & (~req0 | ~last_q);
    wr_in     = sel1 ? we1 : we0;
    be_in     = sel1 ? be1 : be0;
    lane_mask = {{(DW/2){be_q[1]}}, {(DW/2){be_q[0]}}};
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    port_d    = port_q;
    wr_d      = wr_q;
    be_d      = be_q;
    a_d       = a_q;
    d_out_d   = d_out_q;
    d_oe_d    = d_oe_q;
    ce_d      = ce_q;
    oe_d      = oe_q;
    we_d      = we_q;
    lb_d      = lb_q;
    ub_d      = ub_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          state_d = S_SETUP;
          port_d  = sel1;
          last_d  = sel1;
          wr_d    = wr_in;
          be_d    = be_in;
          a_d     = sel1 ? addr1 : addr0;
          d_out_d = sel1 ? wdata1 : wdata0;
          d_oe_d  = wr_in;
          ce_d    = 1'b0;
          oe_d    = 1'b1;
          we_d    = 1'b1;
          lb_d    = ~be_in[0];
          ub_d    = ~be_in[1];
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
        cnt_d   = 4'd0;
        we_d    = ~wr_q;
        oe_d    = wr_q;
      end
      S_ACCESS: begin
        if (cnt_q == LAST_CNT) begin
          state_d = S_DONE;
          we_d    = 1'b1;
          oe_d    = 1'b1;
          ack0_d  = ~port_q;
          ack1_d  = port_q;
          if (!wr_q && !port_q) rdata0_d = D & lane_mask;
          if (!wr_q &&  port_q) rdata1_d = D & lane_mask;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        ce_d    = 1'b1;
        lb_d    = 1'b1;
        ub_d    = 1'b1;
        d_oe_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      last_q   <= 1'b1;
      port_q   <= 1'b0;
      wr_q     <= 1'b0;
      be_q     <= 2'b00;
      a_q      <= '0;
      d_out_q  <= '0;
      d_oe_q   <= 1'b0;
      ce_q     <= 1'b1;
      oe_q     <= 1'b1;
      we_q     <= 1'b1;
      lb_q     <= 1'b1;
      ub_q     <= 1'b1;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      port_q   <= port_d;
      wr_q     <= wr_d;
      be_q     <= be_d;
      a_q      <= a_d;
      d_out_q  <= d_out_d;
      d_oe_q   <= d_oe_d;
      ce_q     <= ce_d;
      oe_q     <= oe_d;
      we_q     <= we_d;
      lb_q     <= lb_d;
      ub_q     <= ub_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign D      = d_oe_q ? d_out_q : {DW{1'bz}};
  assign A      = a_q;
  assign CE     = ce_q;
  assign OE     = oe_q;
  assign WE     = we_q;
  assign LB     = lb_q;
  assign UB     = ub_q;
  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;
  assign busy   = (state_q != S_IDLE);
endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - Directed self-checking bench for sram_arbiter with a behavioural SRAM
module tb_sram_arbiter;
  localparam int AW = 18;
  localparam int DW = 16;
  localparam int WAIT_CYCLES = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic [1:0]    be0 = 2'b00, be1 = 2'b00;
  logic          ack0, ack1, busy, CE, OE, WE, LB, UB;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] A;
  wire  [DW-1:0] D;
  logic [15:0]   mem [0:4095];
  int            errors = 0;
  int            checks = 0;

  sram_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1), .be0(be0), .be1(be1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .CE(CE), .OE(OE), .WE(WE), .LB(LB), .UB(UB), .A(A), .D(D)
  );

  always #5 clk = ~clk;

  // Behavioural async SRAM: drives on CE&OE low, writes enabled lanes on the WE rising edge
  assign D = (CE === 1'b0 && OE === 1'b0 && WE === 1'b1) ? mem[A[11:0]] : 16'bz;
  always @(posedge WE) begin
    if (CE === 1'b0) begin
      if (LB === 1'b0) mem[A[11:0]][7:0]  = D[7:0];
      if (UB === 1'b0) mem[A[11:0]][15:8] = D[15:8];
    end
  end

  task automatic do_txn(input logic port, input logic wr, input logic [AW-1:0] adr,
                        input logic [15:0] wd, input logic [1:0] be,
                        output logic [15:0] rd, output logic acked,
                        output logic lb_s, output logic ub_s);
    acked = 1'b0; rd = '0; lb_s = 1'b1; ub_s = 1'b1;
    if (port) begin we1 = wr; addr1 = adr; wdata1 = wd; be1 = be; req1 = 1'b1; end
    else      begin we0 = wr; addr0 = adr; wdata0 = wd; be0 = be; req0 = 1'b1; end
    for (int i = 0; i < 20 && !acked; i++) begin
      @(negedge clk);
      if (i == 0) begin lb_s = LB; ub_s = UB; end
      if ((port ? ack1 : ack0) === 1'b1) begin
        acked = 1'b1;
        rd = port ? rdata1 : rdata0;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if ({CE, OE, WE, LB, UB} !== 5'b11111) begin errors++; $display("FAIL reset_pins: got %b expected 11111", {CE, OE, WE, LB, UB}); end
    checks++; if (A !== '0) begin errors++; $display("FAIL reset_addr: got %h expected 0", A); end
    checks++; if (dut.d_oe_q !== 1'b0) begin errors++; $display("FAIL reset_d_drive: got %b expected 0", dut.d_oe_q); end
    checks++; if ({ack0, ack1, busy} !== 3'b000) begin errors++; $display("FAIL reset_ack_busy: got %b expected 000", {ack0, ack1, busy}); end
    checks++; if ({rdata0, rdata1} !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", {rdata0, rdata1}); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: got %b expected 0", busy); end
  endtask

  task automatic test_write;
    logic [4:0] ce_t, we_t, drv_t, ack_t;
    ce_t = 5'b10000; we_t = 5'b11001; drv_t = 5'b01111; ack_t = 5'b01000;
    we0 = 1'b1; addr0 = 18'd100; wdata0 = 16'h0006; be0 = 2'b11; req0 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if ({CE, WE, OE} !== {ce_t[c], we_t[c], 1'b1}) begin errors++; $display("FAIL write_ctl c%0d: got CE/WE/OE=%b expected %b", c + 1, {CE, WE, OE}, {ce_t[c], we_t[c], 1'b1}); end
      checks++; if (dut.d_oe_q !== drv_t[c] || (drv_t[c] && D !== 16'h0006)) begin errors++; $display("FAIL write_d c%0d: got drv=%b D=%h expected drv=%b D=0006", c + 1, dut.d_oe_q, D, drv_t[c]); end
      checks++; if ({ack0, ack1} !== {ack_t[c], 1'b0}) begin errors++; $display("FAIL write_ack c%0d: got %b expected %b", c + 1, {ack0, ack1}, {ack_t[c], 1'b0}); end
      if (c < 4) begin
        checks++; if ({A, LB, UB} !== {18'd100, 2'b00}) begin errors++; $display("FAIL write_addr c%0d: got A=%0d LB/UB=%b expected 100 00", c + 1, A, {LB, UB}); end
      end
      if (ack0 === 1'b1) req0 = 1'b0;
    end
    req0 = 1'b0;
  endtask

  task automatic test_read;
    logic [4:0] oe_t, ack_t;
    oe_t = 5'b11001; ack_t = 5'b01000;
    we1 = 1'b0; addr1 = 18'd100; wdata1 = 16'hFFFF; be1 = 2'b11; req1 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if ({OE, WE, dut.d_oe_q} !== {oe_t[c], 2'b10}) begin errors++; $display("FAIL read_ctl c%0d: got OE/WE/drv=%b expected %b", c + 1, {OE, WE, dut.d_oe_q}, {oe_t[c], 2'b10}); end
      checks++; if ({ack1, ack0} !== {ack_t[c], 1'b0}) begin errors++; $display("FAIL read_ack c%0d: got %b expected %b", c + 1, {ack1, ack0}, {ack_t[c], 1'b0}); end
      if (ack_t[c]) begin
        checks++; if (rdata1 !== 16'h0006) begin errors++; $display("FAIL read_data: got %h expected 0006", rdata1); end
        req1 = 1'b0;
      end
    end
    checks++; if (rdata1 !== 16'h0006) begin errors++; $display("FAIL read_hold: got %h expected 0006", rdata1); end
  endtask

  task automatic test_back_to_back;
    int n, prev_ack, ack_cyc [4];
    logic [3:0] order;
    n = 0; prev_ack = 0; order = '0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    we0 = 1'b1; addr0 = 18'd10; wdata0 = 16'h0011; be0 = 2'b11;
    we1 = 1'b1; addr1 = 18'd20; wdata1 = 16'h0022; be1 = 2'b11;
    req0 = 1'b1; req1 = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (prev_ack != 0) begin
        checks++; if ({CE, busy, ack0, ack1} !== 4'b1000) begin errors++; $display("FAIL b2b_turnaround c%0d: got CE/busy/ack0/ack1=%b expected 1000", c, {CE, busy, ack0, ack1}); end
      end
      if (ack0 === 1'b1 || ack1 === 1'b1) begin
        if (n < 4) begin order[n] = ack1; ack_cyc[n] = c; end
        n++;
        if (n == 4) begin req0 = 1'b0; req1 = 1'b0; end
      end
      prev_ack = (ack0 === 1'b1 || ack1 === 1'b1) ? 1 : 0;
    end
    checks++; if (n != 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", n); end
    checks++; if (order !== 4'b1010) begin errors++; $display("FAIL b2b_order: got %b expected 1010 (bit0 first)", order); end
    checks++; if (ack_cyc[0] != WAIT_CYCLES + 2) begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", ack_cyc[0], WAIT_CYCLES + 2); end
    for (int i = 1; i < 4; i++) begin
      checks++; if (ack_cyc[i] - ack_cyc[i-1] != WAIT_CYCLES + 3) begin errors++; $display("FAIL b2b_period %0d: got %0d expected %0d", i, ack_cyc[i] - ack_cyc[i-1], WAIT_CYCLES + 3); end
    end
  endtask

  task automatic test_byte_lanes;
    logic [15:0] rd;
    logic ok, lb_s, ub_s;
    mem[1000] = 16'h1234;
    do_txn(1'b0, 1'b1, 18'd1000, 16'hABCD, 2'b01, rd, ok, lb_s, ub_s);
    checks++; if ({ok, lb_s, ub_s} !== 3'b101) begin errors++; $display("FAIL lane_write: got ack/LB/UB=%b expected 101", {ok, lb_s, ub_s}); end
    do_txn(1'b0, 1'b0, 18'd1000, 16'h0000, 2'b11, rd, ok, lb_s, ub_s);
    checks++; if ({ok, rd} !== {1'b1, 16'h12CD}) begin errors++; $display("FAIL lane_read11: got ack=%b rd=%h expected 1 12CD", ok, rd); end
    do_txn(1'b0, 1'b0, 18'd1000, 16'h0000, 2'b10, rd, ok, lb_s, ub_s);
    checks++; if ({ok, rd, lb_s, ub_s} !== {1'b1, 16'h1200, 2'b10}) begin errors++; $display("FAIL lane_read10: got ack=%b rd=%h LB/UB=%b expected 1 1200 10", ok, rd, {lb_s, ub_s}); end
    do_txn(1'b0, 1'b0, 18'd1000, 16'h0000, 2'b00, rd, ok, lb_s, ub_s);
    checks++; if ({ok, rd, lb_s, ub_s} !== {1'b1, 16'h0000, 2'b11}) begin errors++; $display("FAIL lane_read00: got ack=%b rd=%h LB/UB=%b expected 1 0000 11", ok, rd, {lb_s, ub_s}); end
  endtask

  task automatic test_reset_abort;
    int acks, busys;
    acks = 0; busys = 0;
    we0 = 1'b1; addr0 = 18'd200; wdata0 = 16'h5555; be0 = 2'b11; req0 = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (WE !== 1'b0) begin errors++; $display("FAIL abort_in_access: got WE=%b expected 0", WE); end
    rst = 1'b0; req0 = 1'b0;
    #1;
    checks++; if ({CE, WE, OE, LB, UB, dut.d_oe_q} !== 6'b111110) begin errors++; $display("FAIL abort_pins: got %b expected 111110", {CE, WE, OE, LB, UB, dut.d_oe_q}); end
    checks++; if ({ack0, busy} !== 2'b00) begin errors++; $display("FAIL abort_state: got ack0/busy=%b expected 00", {ack0, busy}); end
    @(negedge clk); rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (ack0 === 1'b1 || ack1 === 1'b1) acks++;
      if (busy !== 1'b0) busys++;
    end
    checks++; if (acks != 0 || busys != 0) begin errors++; $display("FAIL abort_after: got acks=%0d busy_cycles=%0d expected 0 0", acks, busys); end
  endtask

  task automatic test_withdraw;
    int ack1_n, ce_falls, c;
    logic ce_prev, got0, ok, lb_s, ub_s;
    logic [15:0] rd;
    ack1_n = 0; ce_falls = 0; ce_prev = 1'b1; got0 = 1'b0; c = 0;
    we0 = 1'b1; addr0 = 18'd300; wdata0 = 16'h3C3C; be0 = 2'b11; req0 = 1'b1;
    we1 = 1'b0; addr1 = 18'd300; be1 = 2'b11;
    for (c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) req1 = 1'b1;
      if (c == 2) req1 = 1'b0;
      if (ack1 === 1'b1) ack1_n++;
      if (ce_prev === 1'b1 && CE === 1'b0) ce_falls++;
      ce_prev = CE;
      if (ack0 === 1'b1) begin got0 = 1'b1; req0 = 1'b0; end
    end
    checks++; if ({got0, ack1_n[3:0], ce_falls[3:0]} !== {1'b1, 4'd0, 4'd1}) begin errors++; $display("FAIL withdraw: got ack0=%b ack1s=%0d accesses=%0d expected 1 0 1", got0, ack1_n, ce_falls); end
    do_txn(1'b0, 1'b0, 18'd300, 16'h0000, 2'b11, rd, ok, lb_s, ub_s);
    checks++; if ({ok, rd} !== {1'b1, 16'h3C3C}) begin errors++; $display("FAIL withdraw_followup: got ack=%b rd=%h expected 1 3C3C", ok, rd); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    test_reset;
    test_write;
    test_read;
    test_back_to_back;
    test_byte_lanes;
    test_reset_abort;
    test_withdraw;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
